// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg
//   Shared definitions for the nibble-serial adder: FSM state encoding and
//   the datapath nibble width used by the sequencer and full_adder4.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_full_adder4.sv
// full_adder4
//   Combinational 4-bit ripple adder, the per-nibble datapath of the
//   nibble-serial adder.
//   a_i, b_i : nibble operands
//   c_i      : carry-in
//   s_o      : sum nibble
//   c_o      : carry-out
module full_adder4
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                c_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                c_o
);

  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, c_i};

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two WIDTH-bit unsigned operands plus carry-in, one nibble per clock,
//   through a single full_adder4. start/busy/done handshake; result held
//   until the next accepted start.
//   clk, rst_n        : clock (rising edge), async active-low reset
//   start             : request, sampled in IDLE or DONE only
//   a, b, c_in        : operands, captured when start is accepted
//   busy              : high while the nibbles are being processed
//   done              : one-cycle pulse, sum/c_out valid
//   sum, c_out        : result {c_out,sum} = a + b + c_in
//   ovf               : signed overflow, only with NIBBLE_SERIAL_ADDER_OVF_EN
// Optional feature macro: NIBBLE_SERIAL_ADDER_OVF_EN
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e               state_q;
  logic [WIDTH-1:0]     a_sh_q, b_sh_q, sum_sh_q, sum_q;
  logic [WIDTH-1:0]     sum_sh_d;
  logic                 carry_q, busy_q, done_q, cout_q;
  logic [IDX_W-1:0]     idx_q;
  logic [NIBBLE_W-1:0]  fa_s;
  logic                 fa_c;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic                 a_msb_q, b_msb_q, ovf_q;
`endif

  full_adder4 u_fa (
    .a_i (a_sh_q[NIBBLE_W-1:0]),
    .b_i (b_sh_q[NIBBLE_W-1:0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // New sum nibble enters at the MSB end, so after NIB steps the first
  // (least significant) nibble has walked down to bits [3:0].
  if (NIB == 1) begin : g_one
    assign sum_sh_d = fa_s;
  end else begin : g_multi
    assign sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:NIBBLE_W]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      idx_q    <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // DONE accepts start exactly like IDLE for back-to-back operation.
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= c_in;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh_q   <= a_sh_q >> NIBBLE_W;
          b_sh_q   <= b_sh_q >> NIBBLE_W;
          carry_q  <= fa_c;
          sum_sh_q <= sum_sh_d;
          idx_q    <= idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= sum_sh_d;
            cout_q  <= fa_c;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            // fa_s[MSB] is the result MSB on the final nibble.
            ovf_q   <= (a_msb_q == b_msb_q) && (fa_s[NIBBLE_W-1] != a_msb_q);
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder
//   Directed-vector bench for nibble_serial_adder (WIDTH=16). Expected
//   results are queued when an operation is issued; a monitor pops and
//   compares on every done pulse.
module tb_nibble_serial_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk, rst_n, start, c_in;
  logic [15:0] a, b;
  logic        busy, done, c_out;
  logic [15:0] sum;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic        ovf;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        e = sb_q.pop_front();
        chk("sum", {16'h0, sum}, {16'h0, e.s});
        chk("c_out", {31'h0, c_out}, {31'h0, e.c});
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        chk("ovf", {31'h0, ovf}, {31'h0, e.o});
`endif
      end
    end
  end

  // Called #1 after an edge; 'edges' counts edges since acceptance so far.
  task automatic wait_done(input int edges_in, input string nm);
    int edges, busy_n;
    edges  = edges_in;
    busy_n = 0;
    while (done !== 1'b1 && edges < 20) begin
      if (busy === 1'b1) busy_n++;
      @(posedge clk); #1;
      edges++;
    end
    chk({nm, "_latency"}, edges, 5);
    if (edges_in == 1) chk({nm, "_busy_cycles"}, busy_n, 4);
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic [15:0] es, input logic ec, input logic eo, input string nm);
    @(negedge clk);
    a = ta; b = tb_v; c_in = tc; start = 1'b1;
    sb_q.push_back('{s: es, c: ec, o: eo});
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1, nm);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int dcnt;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_sum", {16'h0, sum}, 0);
    chk("rst_cout", {31'h0, c_out}, 0);
    @(negedge clk); rst_n = 1'b1;

    // 1. basic
    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "t1");
    // 2. carry propagation
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "t2a");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "t2b");

    // 3. start during RUN is ignored
    @(negedge clk);
    a = 16'h0F0F; b = 16'h00F1; c_in = 1'b0; start = 1'b1;
    sb_q.push_back('{s: 16'h1000, c: 1'b0, o: 1'b0});
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t3_busy", {31'h0, busy}, 1);
    wait_done(2, "t3");

    // 4. start held high through DONE -> back-to-back accept
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; start = 1'b1;
    sb_q.push_back('{s: 16'h3333, c: 1'b0, o: 1'b0});
    @(posedge clk); #1;
    a = 16'h0001; b = 16'h0001;
    sb_q.push_back('{s: 16'h0002, c: 1'b0, o: 1'b0});
    wait_done(1, "t4a");
    @(posedge clk); #1;
    start = 1'b0;
    chk("t4_busy_b2b", {31'h0, busy}, 1);
    chk("t4_sum_held", {16'h0, sum}, 32'h3333);
    @(posedge clk); #1;
    chk("t4_sum_held2", {16'h0, sum}, 32'h3333);
    wait_done(2, "t4b");

    // 5. async reset mid-RUN
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", {31'h0, busy}, 0);
    chk("t5_done", {31'h0, done}, 0);
    chk("t5_sum", {16'h0, sum}, 0);
    chk("t5_cout", {31'h0, c_out}, 0);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1) dcnt++;
    end
    chk("t5_no_done", dcnt, 0);
    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "t5_after");

    // 6. signed overflow vectors (ovf checked only when the feature is built)
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "t6a");
    run_op(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, "t6b");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
